// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants: core width, boot PC, the fetch
// FSM state encoding and the {pc, inst} entry carried through the queues.
package riscv_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0]     NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a clear that wins over push/pop.
// Used both as the instruction buffer and as the in-flight PC queue.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  input  logic         i_clear,
  output fetch_entry_t o_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [AW:0]  o_count
);

  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  // The owner's credit scheme must make this unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && o_full && !i_clear));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order memory requests and
// buffers returned words for decode. Optional FETCH_MISALIGN_TRAP_EN adds fetch_misaligned.
module fetch_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [XLEN-1:0]       imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic [XLEN-1:0]       inst_pc,
  output logic [XLEN-1:0]       inst_pc_plus4,
  output logic [1:0]            dbg_state,
  output logic [$clog2(DEPTH):0] dbg_kill_cnt
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                  fetch_misaligned
`endif
);
  import riscv_pkg::*;

  // Handshakes: a transfer happens on a cycle where valid && ready at the
  // rising edge; valid never depends on ready, and payload is stable while
  // valid is held without ready.
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_kill_cnt;
  logic            r_misaligned;

  fetch_entry_t    w_inflight_in;
  fetch_entry_t    w_inflight_head;
  fetch_entry_t    w_buf_in;
  fetch_entry_t    w_buf_head;
  logic            w_inflight_full;
  logic            w_inflight_empty;
  logic            w_buf_full;
  logic            w_buf_empty;
  logic [CW-1:0]   w_out_cnt;
  logic [CW-1:0]   w_buf_cnt;
  logic [CW:0]     w_credit_used;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_live;
  logic            w_buf_push;
  logic            w_inst_valid;
  logic            w_inst_fire;
  logic [CW-1:0]   w_kill_run;
  logic [CW-1:0]   w_kill_flush;
  logic [XLEN-1:0] w_redirect_target;
  logic            w_redirect_bad;
  logic            w_unused_bits;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_redirect_target = redirect_pc;
  assign w_redirect_bad    = |redirect_pc[1:0];
  assign fetch_misaligned  = r_misaligned;
`else
  assign w_redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_redirect_bad    = 1'b0;
`endif

  assign w_inst_valid = !w_buf_empty && !redirect_valid;
  assign w_inst_fire  = w_inst_valid && inst_ready;

  // A slot being drained by decode this cycle is already free for a new request,
  // which is what lets a 1-cycle memory sustain one instruction per cycle.
  assign w_credit_used = {1'b0, w_out_cnt} + {1'b0, w_buf_cnt} - (CW+1)'(w_inst_fire);
  assign w_req_valid   = (r_state == S_RUN) && !redirect_valid && !r_misaligned &&
                         (w_credit_used < (CW+1)'(DEPTH));
  assign w_req_fire    = w_req_valid && imem_req_ready;

  // Responses with no matching request (left over from before reset) are dropped.
  assign w_rsp_live   = imem_rsp_valid && !w_inflight_empty;
  assign w_buf_push   = (r_state == S_RUN) && w_rsp_live && !redirect_valid;
  assign w_kill_run   = w_out_cnt - CW'(w_rsp_live);
  assign w_kill_flush = r_kill_cnt - CW'(imem_rsp_valid && (r_kill_cnt != '0));

  assign w_inflight_in = '{pc: r_pc, inst: NOP};
  assign w_buf_in      = '{pc: w_inflight_head.pc, inst: imem_rsp_data};

  fetch_fifo #(.DEPTH(DEPTH)) u_inflight (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_req_fire),
    .i_data  (w_inflight_in),
    .i_pop   (w_rsp_live),
    .i_clear (redirect_valid),
    .o_data  (w_inflight_head),
    .o_full  (w_inflight_full),
    .o_empty (w_inflight_empty),
    .o_count (w_out_cnt)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_buf_push),
    .i_data  (w_buf_in),
    .i_pop   (w_inst_fire),
    .i_clear (redirect_valid),
    .o_data  (w_buf_head),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty),
    .o_count (w_buf_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_kill_cnt   <= '0;
      r_misaligned <= 1'b0;
    end else begin
      if (redirect_valid) begin
        r_pc         <= w_redirect_target;
        r_misaligned <= w_redirect_bad;
      end else if (w_req_fire) begin
        r_pc <= r_pc + XLEN'(4);
      end
      case (r_state)
        S_BOOT: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (redirect_valid) begin
            r_kill_cnt <= w_kill_run;
            r_state    <= (w_kill_run != '0) ? S_FLUSH : S_RUN;
          end
        end
        S_FLUSH: begin
          r_kill_cnt <= w_kill_flush;
          if (w_kill_flush == '0) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = w_inst_valid;
  assign inst           = w_buf_empty ? 32'h0 : w_buf_head.inst;
  assign inst_pc        = w_buf_empty ? '0 : w_buf_head.pc;
  assign inst_pc_plus4  = w_buf_empty ? '0 : pc_plus4(w_buf_head.pc);
  assign dbg_state      = r_state;
  assign dbg_kill_cnt   = r_kill_cnt;

  assign w_unused_bits = ^{w_inflight_head.inst, w_inflight_full, w_buf_full, redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model of
// configurable latency; expected PCs and words are computed here.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_kill_cnt;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int lat     = 1;
  int n_fire  = 0;
  int          pend_due[$];
  logic [31:0] pend_addr[$];
  logic [31:0] exp_q[$];

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc_plus4  (inst_pc_plus4),
    .dbg_state      (dbg_state),
    .dbg_kill_cnt   (dbg_kill_cnt)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    lat            = 1;
    n_fire         = 0;
    pend_due.delete();
    pend_addr.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // One clock: record a request handshake, then drive the memory response
  // due in the next cycle.
  task automatic cycle();
    #1;
    if (imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + lat);
      n_fire++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
  endtask

  initial begin
    // basic fetch, 1-cycle memory
    do_reset();
    #1;
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_pc_plus4", inst_pc_plus4, 32'h0);
    chk("rst_kill", 32'(dbg_kill_cnt), 32'd0);
    cycle(); #1;
    chk("a1_state", 32'(dbg_state), 32'd1);
    chk("a1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("a1_req_addr", imem_req_addr, 32'h0);
    cycle(); #1;
    chk("a2_req_valid", 32'(imem_req_valid), 32'd1);
    chk("a2_req_addr", imem_req_addr, 32'h4);
    chk("a2_inst_valid", 32'(inst_valid), 32'd0);
    cycle(); #1;
    chk("a3_req_valid", 32'(imem_req_valid), 32'd1);
    chk("a3_req_addr", imem_req_addr, 32'h8);
    chk("a3_inst_valid", 32'(inst_valid), 32'd1);
    chk("a3_inst_pc", inst_pc, 32'h0);
    chk("a3_pc_plus4", inst_pc_plus4, 32'h4);
    chk("a3_inst", inst, mem_word(32'h0));
    cycle(); #1;
    chk("a4_inst_valid", 32'(inst_valid), 32'd1);
    chk("a4_inst_pc", inst_pc, 32'h4);
    chk("a4_pc_plus4", inst_pc_plus4, 32'h8);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'h8 + 32'(4 * i));
    end
    for (int i = 0; i < 6; i++) begin
      cycle(); #1;
      chk("a_stream_valid", 32'(inst_valid), 32'd1);
      if (exp_q.size() > 0) begin
        chk("a_stream_pc", inst_pc, exp_q.pop_front());
      end
    end

    // decode stall
    do_reset();
    inst_ready = 1'b0;
    cycle(); #1;
    chk("b1_req_addr", imem_req_addr, 32'h0);
    cycle(); #1;
    chk("b2_req_addr", imem_req_addr, 32'h4);
    for (int k = 0; k < 5; k++) begin
      cycle(); #1;
      chk("b_stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("b_stall_req_addr", imem_req_addr, 32'h8);
      chk("b_stall_inst_valid", 32'(inst_valid), 32'd1);
      chk("b_stall_inst_pc", inst_pc, 32'h0);
    end
    chk("b_stall_fires", 32'(n_fire), 32'd2);
    cycle();
    inst_ready = 1'b1;
    #1;
    chk("b8_inst_pc", inst_pc, 32'h0);
    chk("b8_req_valid", 32'(imem_req_valid), 32'd1);
    chk("b8_req_addr", imem_req_addr, 32'h8);
    cycle(); #1;
    chk("b9_inst_pc", inst_pc, 32'h4);
    rst_n = 1'b0;
    #1;
    chk("b_async_state", 32'(dbg_state), 32'd0);
    chk("b_async_inst_valid", 32'(inst_valid), 32'd0);
    chk("b_async_req_addr", imem_req_addr, 32'h0);

    // memory not ready
    do_reset();
    imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(); #1;
      chk("c_wait_req_valid", 32'(imem_req_valid), 32'd1);
      chk("c_wait_req_addr", imem_req_addr, 32'h0);
    end
    cycle();
    imem_req_ready = 1'b1;
    #1;
    chk("c4_req_addr", imem_req_addr, 32'h0);
    cycle(); #1;
    chk("c5_req_addr", imem_req_addr, 32'h4);

    // redirect with two outstanding, 3-cycle memory
    do_reset();
    lat = 3;
    cycle(); cycle(); cycle(); #1;
    chk("d3_req_valid", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("d3_redir_inst_valid", 32'(inst_valid), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("d4_state", 32'(dbg_state), 32'd2);
    chk("d4_kill", 32'(dbg_kill_cnt), 32'd2);
    chk("d4_req_valid", 32'(imem_req_valid), 32'd0);
    cycle(); #1;
    chk("d5_state", 32'(dbg_state), 32'd2);
    chk("d5_kill", 32'(dbg_kill_cnt), 32'd1);
    chk("d5_inst_valid", 32'(inst_valid), 32'd0);
    cycle(); #1;
    chk("d6_state", 32'(dbg_state), 32'd1);
    chk("d6_req_valid", 32'(imem_req_valid), 32'd1);
    chk("d6_req_addr", imem_req_addr, 32'h100);
    cycle(); #1;
    chk("d7_req_addr", imem_req_addr, 32'h104);
    for (int k = 0; k < 2; k++) begin
      cycle(); #1;
      chk("d_wait_inst_valid", 32'(inst_valid), 32'd0);
    end
    cycle(); #1;
    chk("d10_inst_valid", 32'(inst_valid), 32'd1);
    chk("d10_inst_pc", inst_pc, 32'h100);
    chk("d10_inst", inst, mem_word(32'h100));

    // redirect + response + decode handshake in the same cycle
    do_reset();
    cycle(); cycle(); cycle(); #1;
    chk("e3_inst_valid_pre", 32'(inst_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    chk("e3_inst_valid", 32'(inst_valid), 32'd0);
    chk("e3_req_valid", 32'(imem_req_valid), 32'd0);
    chk("e3_rsp_present", 32'(imem_rsp_valid), 32'd1);
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("e4_state", 32'(dbg_state), 32'd1);
    chk("e4_kill", 32'(dbg_kill_cnt), 32'd0);
    chk("e4_inst_valid", 32'(inst_valid), 32'd0);
    chk("e4_req_addr", imem_req_addr, 32'h40);
    cycle(); #1;
    chk("e5_req_addr", imem_req_addr, 32'h44);
    chk("e5_inst_valid", 32'(inst_valid), 32'd0);
    cycle(); #1;
    chk("e6_inst_valid", 32'(inst_valid), 32'd1);
    chk("e6_inst_pc", inst_pc, 32'h40);
    chk("e6_pc_plus4", inst_pc_plus4, 32'h44);

    // stale response right after reset is ignored
    do_reset();
    cycle();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hdead_dead;
    cycle(); cycle(); #1;
    chk("g3_inst_pc", inst_pc, 32'h0);
    chk("g3_inst", inst, mem_word(32'h0));

    // misaligned redirect target
    do_reset();
    cycle(); cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    cycle();
    redirect_valid = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("f3_misaligned", 32'(fetch_misaligned), 32'd1);
    chk("f3_req_valid", 32'(imem_req_valid), 32'd0);
    cycle(); #1;
    chk("f4_req_valid", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("f5_misaligned", 32'(fetch_misaligned), 32'd0);
    chk("f5_req_valid", 32'(imem_req_valid), 32'd1);
    chk("f5_req_addr", imem_req_addr, 32'h200);
`else
    chk("f3_req_valid", 32'(imem_req_valid), 32'd1);
    chk("f3_req_addr", imem_req_addr, 32'h100);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
